pixel2complex_scan: RTL and testbench
=====================================

# pixel2complex_scan

Parametrised pixel-to-complex-plane mapper for the Julia worker. It converts screen coordinates into signed fixed-point complex values using a runtime-programmable viewport (origin and step). It runs in one of two modes: single-point conversion, or autonomous raster scan of a full frame at up to one point per cycle. Its output feeds the iteration engines through a valid/ready handshake.

## Interface
Parameters:
- COORD_W, 10, width of pixel coordinates
- INT_W, 11, integer bits of the fixed-point format (sign included)
- FRAC_W, 11, fractional bits; WIDTH = INT_W + FRAC_W
- H_RES, 640, pixels per line in scan mode
- V_RES, 480, lines per frame in scan mode

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  reset; synchronous, active-high
- cfg_load  in  1  latches the cfg_* inputs; accepted only in IDLE
- cfg_re_origin  in  WIDTH  signed real value of pixel (0,0)
- cfg_im_origin  in  WIDTH  signed imaginary value of pixel (0,0)
- cfg_step  in  WIDTH  signed complex-plane distance per pixel
- mode  in  1  0 = single, 1 = scan; sampled on an accepted start
- start  in  1  begin a conversion or scan; accepted only in IDLE
- x_in, y_in  in  COORD_W  pixel for single mode; sampled on an accepted start
- abort  in  1  terminates any operation
- busy  out  1  high in every state except IDLE
- out_valid  out  1  z_real, z_imag, x_out and y_out are valid
- out_ready  in  1  consumer accepts the current output
- z_real, z_imag  out  WIDTH  signed Q(INT_W).(FRAC_W) result
- x_out, y_out  out  COORD_W  pixel the result belongs to
- frame_done  out  1  one-cycle pulse when the last scan pixel is accepted

## Operation
- Mapping: z_real = re_origin + x·step and z_imag = im_origin − y·step. Screen y grows downward and the imaginary axis grows upward.
- All arithmetic is two's complement, truncated modulo 2^WIDTH. There is no saturation.
- FSM states are IDLE, MUL, OUT_S and SCAN.
- IDLE:
  - cfg_load → the three config registers are updated on the next edge.
  - start with mode = 0 → MUL; x_in and y_in are captured.
  - start with mode = 1 → SCAN; x = y = 0, acc_re = re_origin, acc_im = im_origin.
  - If start and cfg_load are high together, the config loads and start is ignored.
- MUL: registers the products into z_real and z_imag, then goes to OUT_S.
- OUT_S: out_valid = 1. A handshake (out_valid & out_ready) → IDLE.
- SCAN: out_valid = 1, presenting acc_re, acc_im, x and y. On each handshake:
  - If x < H_RES−1: x+1 and acc_re += step.
  - Otherwise: x = 0, acc_re = re_origin, y+1 and acc_im −= step.
  - On the handshake of pixel (H_RES−1, V_RES−1): frame_done pulses and the FSM goes to IDLE.
- Incremental accumulation must be bit-identical to the single-mode multiply for every pixel, wrap-around included.
- While busy: cfg_load and start are ignored, and the config registers stay stable.
- x_in ≥ H_RES in single mode is converted arithmetically, with no clamping.
- abort, in any state → IDLE on the next edge, with out_valid = 0 and no frame_done. If abort and a handshake coincide, abort wins.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and all config registers are 0.
- Single mode: start sampled at edge k → out_valid high after edge k+2. busy is high from edge k+1 until the handshake edge.
- Scan mode: start sampled at edge k → pixel (0,0) valid after edge k+1.
- Scan throughput: with out_ready held high, one pixel per cycle, so a frame takes H_RES·V_RES cycles.
- While out_valid = 1 and out_ready = 0, all outputs hold stable.
- frame_done is high for exactly the cycle after the final handshake edge. busy is 0 in that same cycle, and a new start is accepted in that cycle.
- rst mid-operation has the same effect as abort, and additionally clears the config registers.

## Test plan
- Single conversion with cfg re_origin = −4096 (−2.0), im_origin = 3072 (1.5) and step = 8 (1/256), input (320,240) → two cycles later z_real = −1536, z_imag = 1152, x_out = 320, y_out = 240; busy drops after the handshake.
- Scan with H_RES = 4, V_RES = 3 and out_ready held high → 12 consecutive outputs in raster order. Pixel (3,2) gives z_real = re_origin + 3·step and z_imag = im_origin − 2·step. frame_done pulses exactly once.
- Backpressure: drop out_ready for 3 cycles mid-scan → outputs are frozen. Resuming yields no skipped or duplicated pixels.
- Wrap-around with re_origin = 2^21−1 and step = 1: single conversion of x = 1 gives z_real = −2^21, and the scan output at x = 1 matches it.
- abort at scan pixel (2,1) → out_valid = 0 next cycle and no frame_done. A following scan start begins again at (0,0).
- cfg_load during a busy scan is ignored (outputs are unchanged). Loading in IDLE then changes the next conversion's result.

Source files
------------

// File: rtl/pixel2complex_scan.sv
// Screen-pixel to complex-plane mapper: single-point multiply or raster scan
// by incremental accumulation, presented on a valid/ready output.
module pixel2complex_scan #(
  parameter int COORD_W = 10,
  parameter int INT_W   = 11,
  parameter int FRAC_W  = 11,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  localparam int WIDTH  = INT_W + FRAC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [WIDTH-1:0]   cfg_re_origin,
  input  logic [WIDTH-1:0]   cfg_im_origin,
  input  logic [WIDTH-1:0]   cfg_step,
  input  logic               mode,
  input  logic               start,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic               abort,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   z_real,
  output logic [WIDTH-1:0]   z_imag,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               frame_done
);

  typedef enum logic [1:0] {IDLE, MUL, OUT_S, SCAN} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] re_origin, im_origin, step;
  logic             hs, start_ok, last_x, last_y, done_nx;

  assign out_valid = (state == OUT_S) || (state == SCAN);
  assign busy      = (state != IDLE);
  assign hs        = out_valid & out_ready;
  // a simultaneous cfg_load takes priority over start
  assign start_ok  = (state == IDLE) & start & ~cfg_load & ~abort;
  assign last_x    = (x_out == COORD_W'(H_RES - 1));
  assign last_y    = (y_out == COORD_W'(V_RES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nx = mode ? SCAN : MUL;
      MUL:   state_nx = OUT_S;
      OUT_S: if (hs) state_nx = IDLE;
      SCAN:  if (hs && last_x && last_y) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
             end
      default: state_nx = IDLE;
    endcase
    if (abort) begin
      state_nx = IDLE;
      done_nx  = 1'b0;
    end
  end

  // All arithmetic is unsigned mod 2^WIDTH, which is bit-identical to the
  // truncated two's-complement result; scan accumulation matches the multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      re_origin  <= '0;
      im_origin  <= '0;
      step       <= '0;
      z_real     <= '0;
      z_imag     <= '0;
      x_out      <= '0;
      y_out      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_nx;
      if (state == IDLE && cfg_load) begin
        re_origin <= cfg_re_origin;
        im_origin <= cfg_im_origin;
        step      <= cfg_step;
      end
      case (state)
        IDLE: if (start_ok) begin
          if (mode) begin
            x_out  <= '0;
            y_out  <= '0;
            z_real <= re_origin;
            z_imag <= im_origin;
          end else begin
            x_out <= x_in;
            y_out <= y_in;
          end
        end
        MUL: if (!abort) begin
          z_real <= re_origin + WIDTH'(x_out) * step;
          z_imag <= im_origin - WIDTH'(y_out) * step;
        end
        SCAN: if (hs && !abort && !(last_x && last_y)) begin
          if (last_x) begin
            x_out  <= '0;
            z_real <= re_origin;
            y_out  <= y_out + 1'b1;
            z_imag <= z_imag - step;
          end else begin
            x_out  <= x_out + 1'b1;
            z_real <= z_real + step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel2complex_scan.sv
// Directed + randomized bench for pixel2complex_scan on a 4x3 frame, checked
// against an arithmetic reference of the viewport mapping.
module tb_pixel2complex_scan;
  localparam int COORD_W = 10;
  localparam int WIDTH   = 22;
  localparam int H_RES   = 4;
  localparam int V_RES   = 3;

  logic               clk = 1'b0;
  logic               rst, cfg_load, mode, start, abort, out_ready;
  logic [WIDTH-1:0]   cfg_re_origin, cfg_im_origin, cfg_step;
  logic [COORD_W-1:0] x_in, y_in;
  logic               busy, out_valid, frame_done;
  logic [WIDTH-1:0]   z_real, z_imag;
  logic [COORD_W-1:0] x_out, y_out;

  int checks = 0;
  int errors = 0;

  // reference viewport as the bench believes it to be loaded
  longint m_re, m_im, m_step;

  pixel2complex_scan #(.COORD_W(COORD_W), .INT_W(11), .FRAC_W(11),
                       .H_RES(H_RES), .V_RES(V_RES)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_re_origin(cfg_re_origin),
    .cfg_im_origin(cfg_im_origin), .cfg_step(cfg_step), .mode(mode),
    .start(start), .x_in(x_in), .y_in(y_in), .abort(abort), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .z_real(z_real),
    .z_imag(z_imag), .x_out(x_out), .y_out(y_out), .frame_done(frame_done));

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] ref_re(input longint x);
    return WIDTH'(m_re + x * m_step);
  endfunction

  function automatic logic [WIDTH-1:0] ref_im(input longint y);
    return WIDTH'(m_im - y * m_step);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_cfg(input longint re, input longint im, input longint st);
    cfg_re_origin = WIDTH'(re);
    cfg_im_origin = WIDTH'(im);
    cfg_step      = WIDTH'(st);
    cfg_load      = 1'b1;
    tick();
    cfg_load      = 1'b0;
    m_re = longint'($signed(cfg_re_origin));
    m_im = longint'($signed(cfg_im_origin));
    m_step = longint'($signed(cfg_step));
  endtask

  task automatic single(input int x, input int y, input int stall);
    mode = 1'b0; x_in = COORD_W'(x); y_in = COORD_W'(y); start = 1'b1;
    tick();
    start = 1'b0;
    chk("single_mul_busy", 32'(busy), 1);
    chk("single_mul_valid", 32'(out_valid), 0);
    tick();
    for (int i = 0; i <= stall; i++) begin
      out_ready = (i == stall);
      chk("single_valid", 32'(out_valid), 1);
      chk("single_zre", 32'(z_real), 32'(ref_re(x)));
      chk("single_zim", 32'(z_imag), 32'(ref_im(y)));
      chk("single_xy", {x_out, 6'd0, y_out}, {COORD_W'(x), 6'd0, COORD_W'(y)});
      if (i < stall) tick();
    end
    tick();
    out_ready = 1'b0;
    chk("single_done_busy", 32'(busy), 0);
    chk("single_done_valid", 32'(out_valid), 0);
  endtask

  // bp: 0 ready always, 1 three-cycle stall at pixel 5, 2 random ready
  task automatic run_scan(input int bp, input int abort_at);
    int ex = 0, ey = 0, idx = 0, stall = 0, cyc = 0;
    bit rdy;
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    while (1) begin
      if (cyc++ > 200) begin
        chk("scan_timeout", 1, 0);
        return;
      end
      if (bp == 0) rdy = 1'b1;
      else if (bp == 1) begin
        rdy = !(idx == 5 && stall < 3);
        if (!rdy) stall++;
      end else rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      chk("scan_valid", 32'(out_valid), 1);
      chk("scan_zre", 32'(z_real), 32'(ref_re(ex)));
      chk("scan_zim", 32'(z_imag), 32'(ref_im(ey)));
      chk("scan_xy", {x_out, 6'd0, y_out}, {COORD_W'(ex), 6'd0, COORD_W'(ey)});
      chk("scan_no_done", 32'(frame_done), 0);
      if (idx == abort_at) begin
        abort = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0;
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_no_done", 32'(frame_done), 0);
        tick();
        chk("abort_no_done2", 32'(frame_done), 0);
        return;
      end
      tick();
      if (rdy) begin
        idx++;
        if (ex == H_RES - 1 && ey == V_RES - 1) break;
        if (ex == H_RES - 1) begin ex = 0; ey++; end
        else ex++;
      end
    end
    out_ready = 1'b0;
    chk("scan_frame_done", 32'(frame_done), 1);
    chk("scan_end_busy", 32'(busy), 0);
    chk("scan_pixels", 32'(idx), H_RES * V_RES);
    if (bp == 0) chk("scan_cycles", 32'(cyc), H_RES * V_RES);
    tick();
    chk("scan_done_once", 32'(frame_done), 0);
  endtask

  initial begin
    rst = 1'b1; cfg_load = 1'b0; mode = 1'b0; start = 1'b0; abort = 1'b0;
    out_ready = 1'b0; x_in = '0; y_in = '0;
    cfg_re_origin = '0; cfg_im_origin = '0; cfg_step = '0;
    m_re = 0; m_im = 0; m_step = 0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_z", 32'({z_real, z_imag} != '0), 0);
    chk("rst_xy", 32'({x_out, y_out}), 0);
    rst = 1'b0;
    tick();

    // documented example: (-2.0, 1.5) origin, 1/256 step
    load_cfg(-4096, 3072, 8);
    single(320, 240, 2);
    chk("example_zre", 32'($signed(z_real)), -32'sd1536);
    chk("example_zim", 32'(z_imag), 1152);

    run_scan(0, -1);
    run_scan(1, -1);

    // wrap-around: max positive origin plus one step
    load_cfg((1 << 21) - 1, 0, 1);
    single(1, 0, 0);
    chk("wrap_zre", 32'(z_real), 32'h200000);
    run_scan(2, -1);

    load_cfg(100, -50, 3);
    run_scan(0, 6);
    run_scan(0, -1);

    // cfg_load while scanning must not disturb the viewport
    mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    cfg_re_origin = 22'h12345; cfg_im_origin = 22'h54321; cfg_step = 22'h777;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("busy_cfg_zre0", 32'(z_real), 32'(ref_re(0)));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("busy_cfg_zre1", 32'(z_real), 32'(ref_re(1)));
    chk("busy_cfg_x1", 32'(x_out), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    single(2, 2, 0);

    // start together with cfg_load: config loads, start ignored
    mode = 1'b0; start = 1'b1; x_in = 10'd5; y_in = 10'd7;
    load_cfg(-777, 999, -5);
    start = 1'b0;
    chk("start_cfg_busy", 32'(busy), 0);
    single(5, 7, 1);

    for (int r = 0; r < 3; r++) begin
      load_cfg(longint'($signed(22'($urandom))), longint'($signed(22'($urandom))),
               longint'($signed(22'($urandom))));
      single(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
             int'($urandom_range(0, 2)));
      run_scan(2, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
